dmem_ctrl: RTL and testbench

Data-memory controller for the pipelined CPU's memory stage. It sits directly downstream of the memory-stage address, data, read and write selection logic. It accepts one word-wide access per request and carries it out byte-serially over a synchronous byte-wide SRAM port. It returns valM plus a dmem_error flag to the status logic, and holds the pipeline through stall while busy.

---
 rtl/dmem_ctrl.sv | 159 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
//   Memory-stage data-memory controller. Accepts one DATA_WID-bit access per
//   request and performs it byte-serially (little-endian) over a synchronous
//   byte-wide SRAM port. Out-of-range or read+write requests are rejected
//   without touching the SRAM; requests with neither read nor write complete
//   immediately.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   read, write            access type
//   addr, wdata            word byte address, store data
//   resp_valid             one-cycle completion pulse
//   valM                   last successful load result
//   dmem_error             error flag, qualified by resp_valid
//   stall                  pipeline hold (!req_ready)
//   sram_en/we/addr/wdata  byte SRAM command port
//   sram_rdata             read byte, valid the cycle after the address
module dmem_ctrl #(
  parameter int DATA_WID  = 64,
  parameter int MEM_BYTES = 4096,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_WID-1:0] addr,
  input  logic [DATA_WID-1:0] wdata,
  output logic                resp_valid,
  output logic [DATA_WID-1:0] valM,
  output logic                dmem_error,
  output logic                stall,
  output logic                sram_en,
  output logic                sram_we,
  output logic [AW-1:0]       sram_addr,
  output logic [7:0]          sram_wdata,
  input  logic [7:0]          sram_rdata
);

  localparam int N  = DATA_WID / 8;
  localparam int CW = $clog2(N) + 1;
  localparam int LW = CW - 1;

  typedef enum logic [1:0] {IDLE, XFER, TAIL, RESP} state_t;

  state_t              r_state;
  state_t              w_next;

  logic [AW-1:0]       r_addr;
  logic [DATA_WID-1:0] r_wdata;
  logic                r_write;
  logic                r_err;
  logic [CW-1:0]       r_cnt;
  logic                r_cap_en;
  logic [LW-1:0]       r_cap_lane;
  logic [DATA_WID-1:0] r_asm;
  logic [DATA_WID-1:0] r_valM;

  logic [DATA_WID:0]   w_end;
  logic                w_err;
  logic                w_noop;
  logic                w_accept;
  logic [DATA_WID-1:0] w_asm_next;

  // End address computed one bit wider than addr so huge addresses cannot wrap
  assign w_end    = {1'b0, addr} + (DATA_WID+1)'(N);
  assign w_err    = (read && write) || (w_end > (DATA_WID+1)'(MEM_BYTES));
  assign w_noop   = !read && !write;
  assign w_accept = req_valid && (r_state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (req_valid) w_next = (w_err || w_noop) ? RESP : XFER;
      XFER: if (r_cnt == CW'(N-1)) w_next = r_write ? RESP : TAIL;
      TAIL: w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dmem_error = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (r_state)
      IDLE: req_ready = 1'b1;
      XFER: begin
        sram_en    = 1'b1;
        sram_we    = r_write;
        sram_addr  = r_addr + AW'(r_cnt);
        sram_wdata = r_wdata[{r_cnt[LW-1:0], 3'b000} +: 8];
      end
      TAIL: ;
      RESP: begin
        resp_valid = 1'b1;
        dmem_error = r_err;
      end
      default: ;
    endcase
    stall = !req_ready;
  end

  // Returned byte merged into its lane; the final byte arrives during TAIL,
  // so valM is loaded from this merged value rather than from r_asm.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_cap_lane, 3'b000} +: 8] = sram_rdata;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_cap_en   <= 1'b0;
      r_cap_lane <= '0;
      r_asm      <= '0;
      r_valM     <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr[AW-1:0];
        r_wdata <= wdata;
        r_write <= write;
        r_err   <= w_err;
        r_cnt   <= '0;
      end else if (r_state == XFER) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Read data lags its address by one cycle: remember which lane it fills
      r_cap_en   <= (r_state == XFER) && !r_write;
      r_cap_lane <= r_cnt[LW-1:0];
      if (r_cap_en) r_asm <= w_asm_next;
      // TAIL is only reached by an error-free read
      if (r_state == TAIL) r_valM <= w_asm_next;
    end
  end

  assign valM = r_valM;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int N  = 8;
  localparam int MB = 4096;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        read;
  logic        write;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        resp_valid;
  logic [63:0] valM;
  logic        dmem_error;
  logic        stall;
  logic        sram_en;
  logic        sram_we;
  logic [11:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata = 8'h00;

  dmem_ctrl #(.DATA_WID(64), .MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .read(read), .write(write), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .valM(valM), .dmem_error(dmem_error), .stall(stall),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: byte memory image and the architectural valM
  logic [7:0]  ref_mem [MB];
  logic [63:0] ref_valM = '0;

  // Synchronous byte SRAM, preloaded from the reference image
  logic [7:0] sram_mem [MB];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MB; i++) sram_mem[i] <= ref_mem[i];
      loaded <= 1'b1;
    end else if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  typedef struct {
    bit          err;
    logic [63:0] valm;
    int          resp_cyc;
    int          n_en;
    int          n_we;
  } exp_t;
  exp_t q[$];

  int cur_acc   = 0;
  int cur_resp  = -1;
  int last_resp = 0;
  bit prev_hold = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each response
  int en_cnt = 0;
  int we_cnt = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0;
      we_cnt = 0;
    end else begin
      chk("stall_vs_ready", stall, !req_ready);
      chk("stall_busy", stall, (cyc >= cur_acc && cyc <= cur_resp));
      if (sram_en) begin
        en_cnt++;
        if (sram_we) we_cnt++;
      end else begin
        chk("sram_idle_zero", {sram_we, sram_addr, sram_wdata}, '0);
      end
      if (!resp_valid) begin
        chk("err_unqualified", dmem_error, 1'b0);
      end else if (q.size() == 0) begin
        chk("unexpected_resp", resp_valid, 1'b0);
      end else begin
        me = q.pop_front();
        chk("resp_cycle", cyc, me.resp_cyc);
        chk("dmem_error", dmem_error, me.err);
        chk("valM", valM, me.valm);
        chk("sram_en_count", en_cnt, me.n_en);
        chk("sram_we_count", we_cnt, me.n_we);
        en_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  // Present a request, wait for acceptance, and (if model) record the
  // expected outcome. Returns 1 time unit after the accepting edge.
  task automatic issue(input bit rd, input bit wr, input logic [63:0] a,
                       input logic [63:0] wd, input bit hold, input bit model);
    int budget;
    int acc;
    int lat;
    logic [64:0] sum;
    exp_t e;
    @(negedge clk);
    read = rd; write = wr; addr = a; wdata = wd; req_valid = 1'b1;
    budget = 0;
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      prev_hold = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (prev_hold) chk("b2b_accept_edge", acc, last_resp + 2);
    if (model) begin
      sum   = {1'b0, a} + 65'd8;
      e.err = (rd && wr) || (sum > 65'd4096);
      e.n_en = 0;
      e.n_we = 0;
      if (e.err || (!rd && !wr)) begin
        lat = 1;
      end else if (wr) begin
        for (int i = 0; i < N; i++) ref_mem[int'(a[11:0]) + i] = wd[8*i +: 8];
        lat = N + 1; e.n_en = N; e.n_we = N;
      end else begin
        for (int i = 0; i < N; i++) ref_valM[8*i +: 8] = ref_mem[int'(a[11:0]) + i];
        lat = N + 2; e.n_en = N;
      end
      e.valm     = ref_valM;
      e.resp_cyc = acc + lat - 1;
      cur_acc    = acc;
      cur_resp   = e.resp_cyc;
      last_resp  = e.resp_cyc;
      q.push_back(e);
    end else begin
      cur_acc  = acc;
      cur_resp = acc + 100000;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    prev_hold = hold && model;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((q.size() != 0 || !req_ready) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_resp"}, resp_valid, 1'b0);
    chk({tag, "_err"}, dmem_error, 1'b0);
    chk({tag, "_valM"}, valM, 64'h0);
    chk({tag, "_sram"}, {sram_en, sram_we, sram_addr, sram_wdata}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] wd;
    int bad;
    int op;
    int ar;
    logic [63:0] a;
    bit h;
    rst_n = 1'b0;
    req_valid = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'($urandom);
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write/read round trip
    issue(1'b0, 1'b1, 64'h100, 64'h0123456789ABCDEF, 1'b0, 1'b1);
    wait_idle();
    chk("mem_0x100", sram_mem[12'h100], 8'hEF);
    chk("mem_0x107", sram_mem[12'h107], 8'h01);
    issue(1'b1, 1'b0, 64'h100, 64'h0, 1'b0, 1'b1);
    wait_idle();
    chk("valM_roundtrip", valM, 64'h0123456789ABCDEF);

    // Upper bound, overflow address, conflict, no-op
    issue(1'b1, 1'b0, 64'hFF8, 64'h0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 64'hFF9, 64'h0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, {$urandom, $urandom}, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 64'h40, {$urandom, $urandom}, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 64'h40, {$urandom, $urandom}, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back reads with req_valid held
    issue(1'b1, 1'b0, 64'h100, 64'h0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 64'h300, 64'h0, 1'b0, 1'b1);
    wait_idle();

    // Reset during a write, after three bytes have been stored
    wd = {$urandom, $urandom};
    issue(1'b0, 1'b1, 64'h200, wd, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    for (int i = 0; i < 3; i++) ref_mem[12'h200 + i] = wd[8*i +: 8];
    ref_valM = '0;
    cur_resp = -1;
    for (int i = 0; i < N; i++) chk("abort_mem_byte", sram_mem[12'h200 + i], ref_mem[12'h200 + i]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      op = $urandom_range(0, 9);
      ar = $urandom_range(0, 9);
      if (ar < 8)       a = 64'($urandom_range(0, MB - N));
      else if (ar == 8) a = 64'($urandom_range(MB - N + 1, MB - 1));
      else              a = {1'b1, 31'($urandom), 32'($urandom)};
      h = (t != 149) && ($urandom_range(0, 1) == 1);
      issue(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8, a, {$urandom, $urandom}, h, 1'b1);
      if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    bad = 0;
    for (int i = 0; i < MB; i++) if (sram_mem[i] !== ref_mem[i]) bad++;
    chk("sram_image_mismatches", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
